// File: rtl/memory_stage.sv
// Pipeline memory stage: single-cycle ALU passthrough, stalling load/store handshake, 255-cycle access timeout.
// Optional execute-stage bypass ports are built when MEM_STAGE_FWD_EN is defined.
module memory_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_alu_result,
    input  logic [15:0] in_store_data,
    input  logic [3:0]  in_rd,
    input  logic        in_wre,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        wb_valid,
    output logic        wb_wre,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        stall_out,
`ifdef MEM_STAGE_FWD_EN
    output logic        fwd_valid,
    output logic [3:0]  fwd_rd,
    output logic [15:0] fwd_data,
`endif
    output logic        mem_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [3:0]  rd_q, rd_d;
    logic        wre_q, wre_d;
    logic        is_load_q, is_load_d;
    logic [7:0]  wait_q, wait_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_wre_q, wb_wre_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        mem_err_q, mem_err_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wre_d      = wre_q;
        is_load_d  = is_load_q;
        wait_d     = wait_q;
        wb_valid_d = 1'b0;
        wb_wre_d   = wb_wre_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        mem_err_d  = mem_err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_mem_read || in_mem_write) begin
                        // A simultaneous read+write request resolves to a load.
                        addr_d    = in_alu_result;
                        wdata_d   = in_store_data;
                        rd_d      = in_rd;
                        wre_d     = in_wre;
                        is_load_d = in_mem_read;
                        wait_d    = 8'd0;
                        state_d   = ACCESS;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = in_alu_result;
                        wb_rd_d    = in_rd;
                        wb_wre_d   = in_wre;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = is_load_q ? mem_rdata : addr_q;
                    wb_wre_d   = is_load_q & wre_q;
                    state_d    = IDLE;
                end else if (wait_q == 8'd254) begin
                    // This cycle takes the counter to 255: abort with a non-writing result.
                    wait_d     = 8'd255;
                    mem_err_d  = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_wre_d   = 1'b0;
                    wb_rd_d    = rd_q;
                    wb_data_d  = 16'h0000;
                    state_d    = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            rd_q       <= 4'h0;
            wre_q      <= 1'b0;
            is_load_q  <= 1'b0;
            wait_q     <= 8'd0;
            wb_valid_q <= 1'b0;
            wb_wre_q   <= 1'b0;
            wb_rd_q    <= 4'h0;
            wb_data_q  <= 16'h0000;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wre_q      <= wre_d;
            is_load_q  <= is_load_d;
            wait_q     <= wait_d;
            wb_valid_q <= wb_valid_d;
            wb_wre_q   <= wb_wre_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Memory request lines are quiet outside ACCESS so IDLE and reset present all zeros.
    assign stall_out = (state_q == ACCESS);
    assign mem_re    = stall_out & is_load_q;
    assign mem_we    = stall_out & ~is_load_q;
    assign mem_addr  = stall_out ? addr_q : 16'h0000;
    assign mem_wdata = stall_out ? wdata_q : 16'h0000;

    assign wb_valid  = wb_valid_q;
    assign wb_wre    = wb_wre_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign mem_err   = mem_err_q;

`ifdef MEM_STAGE_FWD_EN
    assign fwd_valid = wb_valid_q & wb_wre_q;
    assign fwd_rd    = wb_rd_q;
    assign fwd_data  = wb_data_q;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table, directed corner sequences, randomized transactions.
// Bypass port checks are compiled in when MEM_STAGE_FWD_EN is defined.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_alu_result = '0;
    logic [15:0] in_store_data = '0;
    logic [3:0]  in_rd = '0;
    logic        in_wre = 1'b0;
    logic        in_mem_read = 1'b0;
    logic        in_mem_write = 1'b0;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        wb_valid;
    logic        wb_wre;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        stall_out;
    logic        mem_err;
`ifdef MEM_STAGE_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [15:0] fwd_data;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    memory_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_alu_result(in_alu_result),
        .in_store_data(in_store_data),
        .in_rd        (in_rd),
        .in_wre       (in_wre),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .wb_valid     (wb_valid),
        .wb_wre       (wb_wre),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .stall_out    (stall_out),
`ifdef MEM_STAGE_FWD_EN
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
`endif
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        mw;
        logic        wre;
        logic [3:0]  rd;
        logic [15:0] alu;
        logic [15:0] sdata;
        logic [15:0] rdata;
        int          waits;
        logic [15:0] expData;
        logic        expWre;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        #2;
        checkOutput("reset_stall", 32'(stall_out), 32'd0);
        checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset_mem_err", 32'(mem_err), 32'd0);
        checkOutput("reset_mem_re", 32'(mem_re), 32'd0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_wb_data", 32'(wb_data), 32'd0);
        reset = 1'b1;
    endtask

    // Reference: what the writeback should carry for a completed instruction.
    function automatic logic [16:0] refResult(input logic mr, input logic mw, input logic wre,
                                              input logic [15:0] alu, input logic [15:0] rdata);
        if (mr) return {wre, rdata};
        if (mw) return {1'b0, alu};
        return {wre, alu};
    endfunction

    task automatic checkWriteback(input logic [15:0] expData, input logic expWre, input logic [3:0] expRd);
        checkOutput("wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("wb_data", 32'(wb_data), 32'(expData));
        checkOutput("wb_wre", 32'(wb_wre), 32'(expWre));
        checkOutput("wb_rd", 32'(wb_rd), 32'(expRd));
        checkOutput("wb_stall", 32'(stall_out), 32'd0);
`ifdef MEM_STAGE_FWD_EN
        checkOutput("fwd_valid", 32'(fwd_valid), 32'(expWre));
        checkOutput("fwd_data", 32'(fwd_data), 32'(expData));
        checkOutput("fwd_rd", 32'(fwd_rd), 32'(expRd));
`endif
    endtask

    // Drives one instruction from IDLE and follows it to its writeback pulse.
    task automatic applyStimulus(input logic mr, input logic mw, input logic wre, input logic [3:0] rd,
                                 input logic [15:0] alu, input logic [15:0] sdata, input logic [15:0] rdata,
                                 input int waits, input logic [15:0] expData, input logic expWre);
        in_valid = 1'b1;
        in_mem_read = mr;
        in_mem_write = mw;
        in_wre = wre;
        in_rd = rd;
        in_alu_result = alu;
        in_store_data = sdata;
        mem_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_mem_read = 1'b0;
        in_mem_write = 1'b0;
        if (mr || mw) begin
            for (int k = 0; k <= waits; k++) begin
                checkOutput("acc_stall", 32'(stall_out), 32'd1);
                checkOutput("acc_mem_re", 32'(mem_re), 32'(mr));
                checkOutput("acc_mem_we", 32'(mem_we), 32'(mw & ~mr));
                checkOutput("acc_mem_addr", 32'(mem_addr), 32'(alu));
                checkOutput("acc_wb_valid", 32'(wb_valid), 32'd0);
                if (!mr) checkOutput("acc_mem_wdata", 32'(mem_wdata), 32'(sdata));
                if (k == waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata;
                end
                tick();
            end
            mem_ready = 1'b0;
            mem_rdata = $urandom_range(0, 65535);
            checkOutput("done_mem_re", 32'(mem_re), 32'd0);
            checkOutput("done_mem_we", 32'(mem_we), 32'd0);
        end
        checkWriteback(expData, expWre, rd);
        tick();
        checkOutput("wb_pulse_end", 32'(wb_valid), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int pulses;
        int cycles;
        logic [16:0] refVal;

        vecs[0] = '{mr:0, mw:0, wre:1, rd:4'd5, alu:16'h1234, sdata:16'h0000, rdata:16'h0000, waits:0, expData:16'h1234, expWre:1};
        vecs[1] = '{mr:1, mw:0, wre:1, rd:4'd2, alu:16'h0010, sdata:16'h0000, rdata:16'hBEEF, waits:3, expData:16'hBEEF, expWre:1};
        vecs[2] = '{mr:0, mw:1, wre:1, rd:4'd7, alu:16'h0003, sdata:16'h00AA, rdata:16'h0000, waits:0, expData:16'h0003, expWre:0};
        vecs[3] = '{mr:1, mw:1, wre:1, rd:4'd9, alu:16'h0040, sdata:16'h7777, rdata:16'h5A5A, waits:1, expData:16'h5A5A, expWre:1};
        vecs[4] = '{mr:0, mw:0, wre:0, rd:4'hF, alu:16'hFFFF, sdata:16'h0000, rdata:16'h0000, waits:0, expData:16'hFFFF, expWre:0};
        vecs[5] = '{mr:1, mw:0, wre:0, rd:4'd1, alu:16'h2000, sdata:16'h0000, rdata:16'hC0DE, waits:2, expData:16'hC0DE, expWre:0};
        vecs[6] = '{mr:0, mw:1, wre:0, rd:4'd3, alu:16'h8001, sdata:16'h1357, rdata:16'h0000, waits:2, expData:16'h8001, expWre:0};

        #3;
        doReset();
        tick();

        foreach (vecs[i])
            applyStimulus(vecs[i].mr, vecs[i].mw, vecs[i].wre, vecs[i].rd, vecs[i].alu, vecs[i].sdata,
                          vecs[i].rdata, vecs[i].waits, vecs[i].expData, vecs[i].expWre);

        // Ready arriving on the very cycle the counter would hit 255 is a normal completion.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd6, 16'h0100, 16'h0000, 16'h4321, 254, 16'h4321, 1'b1);
        checkOutput("edge255_no_err", 32'(mem_err), 32'd0);

        // Timeout: ready never comes.
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_wre = 1'b1; in_rd = 4'd4;
        in_alu_result = 16'h0050;
        tick();
        in_valid = 1'b0; in_mem_read = 1'b0;
        cycles = 0;
        while (stall_out === 1'b1 && cycles < 300) begin
            cycles++;
            tick();
        end
        checkOutput("timeout_cycles", 32'(cycles), 32'd255);
        checkOutput("timeout_err", 32'(mem_err), 32'd1);
        checkOutput("timeout_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("timeout_wb_wre", 32'(wb_wre), 32'd0);
        checkOutput("timeout_idle", 32'(stall_out), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd8, 16'h0A0A, 16'h0000, 16'h0000, 0, 16'h0A0A, 1'b1);
        checkOutput("err_sticky", 32'(mem_err), 32'd1);
        doReset();
        checkOutput("err_cleared", 32'(mem_err), 32'd0);
        tick();

        // Reset during the second ACCESS cycle.
        in_valid = 1'b1; in_mem_read = 1'b1; in_wre = 1'b1; in_rd = 4'd2; in_alu_result = 16'h0077;
        tick();
        in_valid = 1'b0; in_mem_read = 1'b0;
        tick();
        checkOutput("pre_reset_stall", 32'(stall_out), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 16'h9999;
        doReset();
        checkOutput("midreset_mem_addr", 32'(mem_addr), 32'd0);
        mem_ready = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (wb_valid === 1'b1) pulses++;
        end
        checkOutput("midreset_no_wb", 32'(pulses), 32'd0);
        checkOutput("midreset_idle", 32'(stall_out), 32'd0);

        // Load then ALU op held during the stall.
        pulses = 0;
        in_valid = 1'b1; in_mem_read = 1'b1; in_wre = 1'b1; in_rd = 4'd10; in_alu_result = 16'h0300;
        tick();
        in_mem_read = 1'b0; in_rd = 4'd11; in_alu_result = 16'h5555; in_wre = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checkOutput("b2b_stall", 32'(stall_out), 32'd1);
            if (wb_valid === 1'b1) pulses++;
            if (c == 2) begin
                mem_ready = 1'b1;
                mem_rdata = 16'hAB12;
            end
            tick();
        end
        mem_ready = 1'b0;
        if (wb_valid === 1'b1) pulses++;
        checkWriteback(16'hAB12, 1'b1, 4'd10);
        tick();
        if (wb_valid === 1'b1) pulses++;
        checkWriteback(16'h5555, 1'b1, 4'd11);
        in_valid = 1'b0;
        tick();
        if (wb_valid === 1'b1) pulses++;
        checkOutput("b2b_pulses", 32'(pulses), 32'd2);

        // Randomized transactions against the reference rules.
        for (int n = 0; n < 40; n++) begin
            logic mr, mw, wre;
            logic [3:0] rd;
            logic [15:0] alu, sdata, rdata;
            int waits;
            mr = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            wre = 1'($urandom_range(0, 1));
            rd = 4'($urandom_range(0, 15));
            alu = 16'($urandom_range(0, 65535));
            sdata = 16'($urandom_range(0, 65535));
            rdata = 16'($urandom_range(0, 65535));
            waits = int'($urandom_range(0, 5));
            refVal = refResult(mr, mw, wre, alu, rdata);
            applyStimulus(mr, mw, wre, rd, alu, sdata, rdata, waits, refVal[15:0], refVal[16]);
        end
        checkOutput("final_no_err", 32'(mem_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
